// File: rtl/mem_map_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_map_pkg
// Description : Address map constants and decode helpers shared by the
//               memory-side responder.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_map_pkg;

    localparam logic [31:0] ADDR_IO_DATA    = 32'h0003_0000;
    localparam logic [31:0] ADDR_IO_CLK     = 32'h0003_0004;
    localparam logic [1:0]  REGION_IO       = 2'b11;
    localparam logic [1:0]  REGION_UNMAPPED = 2'b10;
    localparam logic [31:0] RAM_BYTES       = 32'h0002_0000;

    // Regions 00 and 01 together cover the 128 KB RAM.
    function automatic logic is_ram_region(input logic [1:0] region);
        return ~region[1];
    endfunction

endpackage : mem_map_pkg
`default_nettype wire

// File: rtl/byte_fifo.sv
`default_nettype none
// ============================================================================
// Module      : byte_fifo
// Description : Small synchronous byte FIFO. Pops are ignored when empty;
//               a push while full is accepted only if a pop happens in the
//               same cycle. DEPTH must be a power of two, at least 2.
//               Read data is zero whenever the FIFO is empty.
// Revision    : 1.0 - initial release
// ============================================================================
module byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_push,
    input  logic [7:0] i_data,
    input  logic       i_pop,
    output logic [7:0] o_data,
    output logic       o_full,
    output logic       o_empty
);

    localparam int                 c_PTR_W = $clog2(DEPTH);
    localparam logic [c_PTR_W:0]   c_DEPTH = (c_PTR_W + 1)'(DEPTH);
    localparam logic [c_PTR_W:0]   c_ONE   = (c_PTR_W + 1)'(1);
    localparam logic [c_PTR_W-1:0] c_PINC  = c_PTR_W'(1);

    logic [7:0]         r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;
    logic               w_pop;
    logic               w_push;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == c_DEPTH);
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!o_full || w_pop);
    assign o_data  = o_empty ? 8'h00 : r_mem[r_rd_ptr];

    // Storage array; contents need no reset since the count gates the output.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PINC;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PINC;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_ONE;
                2'b01:   r_count <= r_count - c_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : byte_fifo
`default_nettype wire

// File: rtl/mem_io_responder.sv
`default_nettype none
// ============================================================================
// Module      : mem_io_responder
// Description : Dual-port RAM plus I/O window answering the CPU's instruction
//               port (A, read-only) and load/store port (B) with a fixed
//               one-cycle read latency. I/O: byte input stream, byte output
//               stream, cycle counter and a sticky halt flag.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_io_responder
    import mem_map_pkg::*;
#(
    parameter int    MEM_ADDR_WIDTH = 32,
    parameter int    MEM_DATA_WIDTH = 32,
    parameter int    RAM_WORDS      = 32768,
    parameter int    IN_FIFO_DEPTH  = 4,
    parameter int    OUT_FIFO_DEPTH = 4,
    parameter string INIT_FILE      = ""
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic [MEM_ADDR_WIDTH-1:0] mem_addr_a,
    output logic [MEM_DATA_WIDTH-1:0] mem_data_a,
    input  logic                      mem_wr_b,
    input  logic [MEM_DATA_WIDTH-1:0] mem_src_b,
    input  logic [MEM_ADDR_WIDTH-1:0] mem_addr_b,
    output logic [MEM_DATA_WIDTH-1:0] mem_data_b,
    input  logic                      in_valid,
    input  logic [7:0]                in_data,
    output logic                      in_ready,
    output logic                      out_valid,
    output logic [7:0]                out_data,
    input  logic                      out_ready,
    output logic                      halted,
    output logic                      out_overflow
);

    localparam int                        c_IDX_W = $clog2(RAM_WORDS);
    localparam logic [MEM_DATA_WIDTH-1:0] c_INC   = MEM_DATA_WIDTH'(1);

    logic [MEM_DATA_WIDTH-1:0] r_ram [RAM_WORDS];
    logic [MEM_DATA_WIDTH-1:0] r_data_a;
    logic [MEM_DATA_WIDTH-1:0] r_data_b;
    logic [MEM_DATA_WIDTH-1:0] r_cycle;
    logic                      r_halted;
    logic                      r_overflow;

    logic [c_IDX_W-1:0]        w_idx_a;
    logic [c_IDX_W-1:0]        w_idx_b;
    logic                      w_ram_a;
    logic                      w_ram_b;
    logic                      w_io_data;
    logic                      w_io_clk;
    logic                      w_wr_ok;
    logic                      w_in_push;
    logic                      w_in_pop;
    logic [7:0]                w_in_dout;
    logic                      w_in_full;
    logic                      w_in_empty;
    logic                      w_out_push;
    logic                      w_out_pop;
    logic [7:0]                w_out_byte;
    logic                      w_out_full;
    logic                      w_out_empty;
    logic [MEM_DATA_WIDTH-1:0] w_io_rd;
    logic                      w_unused_bits;

    // ---------------------------------------------------------------- decode
    assign w_idx_a   = mem_addr_a[c_IDX_W+1:2];
    assign w_idx_b   = mem_addr_b[c_IDX_W+1:2];
    assign w_ram_a   = is_ram_region(mem_addr_a[17:16]);
    assign w_ram_b   = is_ram_region(mem_addr_b[17:16]);
    assign w_io_data = (mem_addr_b[17:16] == REGION_IO) &&
                       (mem_addr_b[15:2] == ADDR_IO_DATA[15:2]);
    assign w_io_clk  = (mem_addr_b[17:16] == REGION_IO) &&
                       (mem_addr_b[15:2] == ADDR_IO_CLK[15:2]);

    // Once halted, every B write is dropped; reads keep working.
    assign w_wr_ok    = mem_wr_b && !r_halted;

    assign w_in_push  = in_valid && !w_in_full;
    assign w_in_pop   = !mem_wr_b && w_io_data;
    assign w_out_push = w_wr_ok && ((w_io_data && (mem_src_b[7:0] != 8'h00)) || w_io_clk);
    assign w_out_byte = w_io_clk ? 8'h00 : mem_src_b[7:0];
    assign w_out_pop  = out_ready && !w_out_empty;

    // I/O read data; a popped byte is zero when the input FIFO is empty.
    assign w_io_rd = (mem_wr_b || !(w_io_data || w_io_clk)) ? '0 :
                     w_io_clk ? r_cycle :
                     {{(MEM_DATA_WIDTH-8){1'b0}}, w_in_dout};

    assign w_unused_bits = ^{mem_addr_a[MEM_ADDR_WIDTH-1:18], mem_addr_a[1:0],
                             mem_addr_b[MEM_ADDR_WIDTH-1:18], mem_addr_b[1:0]};

    // ------------------------------------------------------------------- RAM
    // Port B write; contents survive reset.
    always_ff @(posedge clk_in) begin
        if (w_wr_ok && w_ram_b) begin
            r_ram[w_idx_b] <= mem_src_b;
        end
    end

    // Port A registered read; non-RAM regions read as zero.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_data_a <= '0;
        end else if (w_ram_a) begin
            r_data_a <= r_ram[w_idx_a];
        end else begin
            r_data_a <= '0;
        end
    end

    // Port B registered read; RAM returns the old word even on a write.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_data_b <= '0;
        end else if (w_ram_b) begin
            r_data_b <= r_ram[w_idx_b];
        end else begin
            r_data_b <= w_io_rd;
        end
    end

    // Free-running cycle counter and sticky status flags.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_cycle    <= '0;
            r_halted   <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_cycle <= r_cycle + c_INC;
            if (w_wr_ok && w_io_clk) begin
                r_halted <= 1'b1;
            end
            if (w_out_push && w_out_full && !w_out_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // ----------------------------------------------------------------- FIFOs
    byte_fifo #(
        .DEPTH   (IN_FIFO_DEPTH)
    ) u_in_fifo (
        .clk     (clk_in),
        .rst     (rst_in),
        .i_push  (w_in_push),
        .i_data  (in_data),
        .i_pop   (w_in_pop),
        .o_data  (w_in_dout),
        .o_full  (w_in_full),
        .o_empty (w_in_empty)
    );

    byte_fifo #(
        .DEPTH   (OUT_FIFO_DEPTH)
    ) u_out_fifo (
        .clk     (clk_in),
        .rst     (rst_in),
        .i_push  (w_out_push),
        .i_data  (w_out_byte),
        .i_pop   (w_out_pop),
        .o_data  (out_data),
        .o_full  (w_out_full),
        .o_empty (w_out_empty)
    );

    assign mem_data_a   = r_data_a;
    assign mem_data_b   = r_data_b;
    assign in_ready     = !w_in_full;
    assign out_valid    = !w_out_empty;
    assign halted       = r_halted;
    assign out_overflow = r_overflow;

endmodule : mem_io_responder
`default_nettype wire
